motor_ramp_controller: RTL
==========================

MOTOR_RAMP_CONTROLLER -- requirements
Module: motor_ramp_controller

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100_000_000, meaning clk frequency in Hz.
REQ-002 SHALL have parameter STEP_HZ, default 1_000, meaning ramp tick rate; TICK_DIV = CLK_FREQ/STEP_HZ clocks per tick.
REQ-003 SHALL have parameter STEP, default 1, meaning duty change per tick (1..255).
REQ-004 SHALL have parameter MIN_RUN_DUTY, default 64, meaning the duty at or above which tach pulses are expected.
REQ-005 SHALL have parameter STALL_TICKS, default 500, meaning ticks without a tach edge that declare a stall.
REQ-006 SHALL have port clk, input, 1, system clock; reset reset, asynchronous, active-high; clock clk.
REQ-007 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-008 SHALL have port cmd_valid, input, 1, target-duty command valid.
REQ-009 SHALL have port cmd_ready, output, 1, controller accepts a command.
REQ-010 SHALL have port cmd_duty, input, 8, requested target duty (0..255).
REQ-011 SHALL have port tach_in, input, 1, asynchronous motor tachometer pulse.
REQ-012 SHALL have port fault_clear, input, 1, single-cycle request to leave FAULT.
REQ-013 SHALL have port duty_cycle, output, 8, duty for pwm_generator.duty_cycle.
REQ-014 SHALL have port motor_en, output, 1, high in RAMP or HOLD.
REQ-015 SHALL have port busy, output, 1, high in RAMP.
REQ-016 SHALL have port at_target, output, 1, high when duty_cycle equals the target and state is not FAULT.
REQ-017 SHALL have port fault, output, 1, high in FAULT.

Function
REQ-018 SHALL run a free counter 0..TICK_DIV-1 and pulse tick for one cycle when it equals TICK_DIV-1.
REQ-019 SHALL register all outputs; cmd_ready SHALL be 1 in every state except FAULT.
REQ-020 SHALL capture cmd_duty into target on cmd_valid && cmd_ready; the new target takes effect the next cycle, and a tick in the accept cycle steps toward the old target.
REQ-021 SHALL implement states IDLE, RAMP, HOLD, FAULT.
REQ-022 IDLE: duty_cycle 0; SHALL go to RAMP when target != 0.
REQ-023 RAMP: on each tick, SHALL move duty_cycle toward target by STEP; if |target-duty_cycle| <= STEP, duty_cycle = target, with no overflow or underflow.
REQ-024 RAMP: SHALL go to HOLD when duty_cycle == target != 0, and to IDLE when duty_cycle == target == 0.
REQ-025 HOLD: SHALL go to RAMP when target != duty_cycle; a command equal to the current duty causes no transition.
REQ-026 A new command accepted mid-ramp SHALL retarget, reversing direction if required, without returning to IDLE.
REQ-027 SHALL synchronise tach_in with 2 flops and detect rising edges.
REQ-028 Stall counter: SHALL increment on tick while duty_cycle >= MIN_RUN_DUTY, and clear on a tach edge or when duty_cycle < MIN_RUN_DUTY; a tach edge in the same cycle as a tick SHALL win (counter cleared).
REQ-029 When the stall counter reaches STALL_TICKS, SHALL enter FAULT next cycle: duty_cycle 0, target 0, motor_en 0, cmd_ready 0, and fault 1 in that same cycle.
REQ-030 FAULT: SHALL ignore cmd_valid; fault_clear SHALL go to IDLE next cycle with the stall counter cleared.

Reset
REQ-031 On reset, SHALL set state IDLE, target 0, all counters 0, and sync flops 0.
REQ-032 On reset, SHALL set outputs duty_cycle 0, motor_en 0, busy 0, at_target 0, fault 0 and cmd_ready 0.
REQ-033 SHALL take effect immediately on reset assertion, including mid-ramp or in FAULT.
REQ-034 cmd_ready SHALL rise on the first clk edge after reset release.

Structure
REQ-035 Package lidar_motor_pkg SHALL hold the state enum and the default parameter constants.
REQ-036 Sub-module tach_edge_sync SHALL contain the 2-flop synchroniser and rising-edge detector.
REQ-037 The block SHALL NOT instantiate pwm_generator; the two are connected at integration.

Verification
All scenarios use TICK_DIV=10, STEP=4, MIN_RUN_DUTY=64, STALL_TICKS=3, and tach edges every tick unless stated otherwise.
REQ-038 Release reset, then cmd 100 -> duty_cycle 4, 8, … 100 one step per 10 clocks, then HOLD, at_target=1, busy=0.
REQ-039 At duty 40, cmd 20 -> duty_cycle 36, 32, 28, 24, 20, then HOLD.
REQ-040 From 0, cmd 10 -> duty_cycle 4, 8, 10; cmd 10 again in HOLD -> no change.
REQ-041 Hold duty 100 and stop tach for 3 ticks -> fault=1, duty_cycle 0, cmd_ready 0; cmd 50 ignored; fault_clear -> IDLE, cmd_ready 1.
REQ-042 In HOLD at 100, cmd 0 -> ramp down to 0, then IDLE, motor_en 0; duty <64 with no tach -> no fault.
REQ-043 Assert reset at duty 48 mid-ramp -> all outputs 0 immediately; after release, state IDLE.

Source files
------------

// File: rtl/lidar_motor_pkg.sv
// Shared types and default constants for the lidar spindle motor ramp controller.
package lidar_motor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RAMP  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  localparam int DEF_CLK_FREQ     = 100_000_000;
  localparam int DEF_STEP_HZ      = 1_000;
  localparam int DEF_STEP         = 1;
  localparam int DEF_MIN_RUN_DUTY = 64;
  localparam int DEF_STALL_TICKS  = 500;

endpackage

// File: rtl/tach_edge_sync.sv
// Two-flop synchroniser for the asynchronous tachometer input plus a
// rising-edge detector on the synchronised signal.
module tach_edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic tach_in,
  output logic tach_edge
);

  logic tach_meta;
  logic tach_sync;
  logic tach_prev;

  // Resynchronise tach_in and keep one delayed copy for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tach_meta <= 1'b0;
      tach_sync <= 1'b0;
      tach_prev <= 1'b0;
    end else begin
      tach_meta <= tach_in;
      tach_sync <= tach_meta;
      tach_prev <= tach_sync;
    end
  end

  assign tach_edge = tach_sync & ~tach_prev;

endmodule

// File: rtl/motor_ramp_controller.sv
// Ramps the motor PWM duty toward a commanded target at a fixed tick rate and
// trips into FAULT when the tachometer stops pulsing while the motor should run.
module motor_ramp_controller
  import lidar_motor_pkg::*;
#(
  parameter int CLK_FREQ     = DEF_CLK_FREQ,
  parameter int STEP_HZ      = DEF_STEP_HZ,
  parameter int STEP         = DEF_STEP,
  parameter int MIN_RUN_DUTY = DEF_MIN_RUN_DUTY,
  parameter int STALL_TICKS  = DEF_STALL_TICKS
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_duty,
  input  logic       tach_in,
  input  logic       fault_clear,
  output logic [7:0] duty_cycle,
  output logic       motor_en,
  output logic       busy,
  output logic       at_target,
  output logic       fault
);

  localparam int TICK_DIV = CLK_FREQ / STEP_HZ;
  localparam int TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int STALL_W  = $clog2(STALL_TICKS + 1);

  state_t             state;
  state_t             state_n;
  logic [7:0]         target;
  logic [7:0]         target_n;
  logic [7:0]         duty_n;
  logic [STALL_W-1:0] stall_cnt;
  logic [STALL_W-1:0] stall_n;
  logic [TICK_W-1:0]  tick_cnt;
  logic               tick;
  logic               tach_edge;
  logic               accept;
  logic               motor_en_n;
  logic               busy_n;
  logic               at_target_n;
  logic               fault_n;
  logic               cmd_ready_n;

  // One step of at most STEP toward tgt; lands exactly on tgt when close,
  // so the result never wraps past 0 or 255.
  function automatic logic [7:0] step_toward(input logic [7:0] cur,
                                             input logic [7:0] tgt);
    logic [8:0] gap;
    logic [7:0] res;
    res = cur;
    if (tgt > cur) begin
      gap = {1'b0, tgt} - {1'b0, cur};
      res = (gap <= 9'(STEP)) ? tgt : cur + 8'(STEP);
    end else if (tgt < cur) begin
      gap = {1'b0, cur} - {1'b0, tgt};
      res = (gap <= 9'(STEP)) ? tgt : cur - 8'(STEP);
    end
    return res;
  endfunction

  tach_edge_sync u_tach_edge_sync (
    .clk       (clk),
    .reset     (reset),
    .tach_in   (tach_in),
    .tach_edge (tach_edge)
  );

  assign tick   = (tick_cnt == TICK_W'(TICK_DIV - 1));
  assign accept = cmd_valid && cmd_ready;

  // Free-running tick divider.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TICK_W'(1);
    end
  end

  // Next state, next duty/target, stall supervision and next output values.
  always_comb begin
    state_n  = state;
    duty_n   = duty_cycle;
    target_n = target;
    stall_n  = stall_cnt;

    if (accept) begin
      target_n = cmd_duty;
    end

    // A tach edge takes priority over a simultaneous tick.
    if (tach_edge || (int'(duty_cycle) < MIN_RUN_DUTY)) begin
      stall_n = '0;
    end else if (tick && (stall_cnt != STALL_W'(STALL_TICKS))) begin
      stall_n = stall_cnt + STALL_W'(1);
    end

    case (state)
      ST_IDLE: begin
        duty_n = 8'd0;
        if (target != 8'd0) begin
          state_n = ST_RAMP;
        end
      end
      ST_RAMP: begin
        // Steps use the target held this cycle; a command accepted now
        // only redirects the ramp from the next cycle on.
        if (tick) begin
          duty_n = step_toward(duty_cycle, target);
        end
        if (duty_cycle == target) begin
          state_n = (target == 8'd0) ? ST_IDLE : ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (target != duty_cycle) begin
          state_n = ST_RAMP;
        end
      end
      ST_FAULT: begin
        duty_n   = 8'd0;
        target_n = 8'd0;
        stall_n  = fault_clear ? '0 : stall_cnt;
        if (fault_clear) begin
          state_n = ST_IDLE;
        end
      end
      default: begin
        state_n = ST_IDLE;
        duty_n  = 8'd0;
      end
    endcase

    // Stall trip overrides everything so fault and zero duty appear together.
    if ((state != ST_FAULT) && (stall_n == STALL_W'(STALL_TICKS))) begin
      state_n  = ST_FAULT;
      duty_n   = 8'd0;
      target_n = 8'd0;
    end

    motor_en_n  = (state_n == ST_RAMP) || (state_n == ST_HOLD);
    busy_n      = (state_n == ST_RAMP);
    fault_n     = (state_n == ST_FAULT);
    cmd_ready_n = (state_n != ST_FAULT);
    at_target_n = (duty_n == target_n) && (state_n != ST_FAULT);
  end

  // State, target, duty and stall counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      target     <= 8'd0;
      duty_cycle <= 8'd0;
      stall_cnt  <= '0;
    end else begin
      state      <= state_n;
      target     <= target_n;
      duty_cycle <= duty_n;
      stall_cnt  <= stall_n;
    end
  end

  // Registered status outputs, aligned with the state they describe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      motor_en  <= 1'b0;
      busy      <= 1'b0;
      at_target <= 1'b0;
      fault     <= 1'b0;
      cmd_ready <= 1'b0;
    end else begin
      motor_en  <= motor_en_n;
      busy      <= busy_n;
      at_target <= at_target_n;
      fault     <= fault_n;
      cmd_ready <= cmd_ready_n;
    end
  end

endmodule
